prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter DEPTH, default 16: program memory entries; address width is log2(DEPTH).
REQ-002 Parameter TIMEOUT, default 64: maximum cycles to wait for i_con_pcincr before the block faults.
REQ-003 The port list SHALL be exactly as follows.
- i_clk  input  1: single clock; all state changes on its rising edge.
- i_rst  input  1: asynchronous, active-low reset.
- i_run  input  1: start or restart the program from address 0.
- i_stop  input  1: request a stop after the current instruction.
- i_wr_en  input  1: program-memory write strobe.
- i_wr_addr  input  4: write address.
- i_wr_data  input  4: bit3 = halt marker; bits2:0 = opcode.
- i_con_pcincr  input  1: instruction-complete pulse from the bit-serial core.
- o_data_instruction  output  3: opcode presented to the core.
- o_start  output  1: one-cycle issue pulse to the core.
- o_pc  output  4: current program counter.
- o_busy  output  1: high in ISSUE and WAIT.
- o_halted  output  1: high in HALT.
- o_fault  output  1: high in FAULT.

Function
REQ-004 States SHALL be IDLE, ISSUE, WAIT, HALT and FAULT.
REQ-005 IDLE: when i_run=1, pc<=0 and next state is ISSUE.
REQ-006 ISSUE lasts one cycle.
- If mem[pc][3]=1: o_start=0 and next state is HALT.
- Otherwise: o_start=1 and next state is WAIT.
REQ-007 o_data_instruction SHALL equal mem[pc][2:0] in ISSUE and WAIT, and stay stable throughout WAIT; it is 0 in all other states.
REQ-008 WAIT:
- The timeout counter increments each cycle.
- On i_con_pcincr=1: pc<=pc+1, wrapping from DEPTH-1 to 0; the counter clears; next state is IDLE if a stop is pending, otherwise ISSUE.
REQ-009 If the counter reaches TIMEOUT-1 without i_con_pcincr, next state is FAULT and pc is held.
REQ-010 If i_con_pcincr and the timeout coincide, i_con_pcincr wins.
REQ-011 i_con_pcincr SHALL be ignored in IDLE, ISSUE, HALT and FAULT.
REQ-012 Stop handling:
- An i_stop=1 sampled in ISSUE or WAIT sets a sticky stop_pending.
- stop_pending clears on entry to IDLE, HALT or FAULT.
- i_stop in any other state has no effect.
REQ-013 In HALT or FAULT, i_run=1 sets pc<=0, clears the fault and goes to ISSUE; nothing else leaves these states except reset.
REQ-014 Back-to-back issue: after i_con_pcincr in cycle t, o_start for the next instruction SHALL be high in cycle t+1.
REQ-015 Run latency: i_run sampled at edge t gives o_start high in the cycle following edge t.
REQ-016 Memory writes:
- Performed at the clock edge when i_wr_en=1 and state is IDLE, HALT or FAULT.
- Ignored in ISSUE and WAIT.
REQ-017 Write and i_run in the same cycle: the write completes first, and ISSUE reads the updated contents.
REQ-018 o_pc SHALL always reflect the registered pc.
REQ-019 o_start is never high in consecutive cycles.

Reset
REQ-020 While i_rst=0, the following SHALL hold immediately, without a clock:
- state=IDLE, pc=0, counter=0, stop_pending=0.
- All memory entries = 0.
- o_start=0, o_busy=0, o_halted=0, o_fault=0, o_data_instruction=0.
REQ-021 Reset asserted mid-WAIT SHALL abandon the instruction with no further o_start.
REQ-022 Release of i_rst SHALL be synchronous to i_clk.

Structure
REQ-023 The shared package bit_serial_pkg SHALL hold:
- the opcode width (3) and memory word width (4);
- the DEPTH and TIMEOUT defaults;
- the sequencer state enum.
REQ-024 Program storage SHALL be a separate sub-module, prog_mem: DEPTH x 4 flop array, asynchronous read, synchronous write, async active-low reset.
REQ-025 The FSM, pc, timeout counter and stop_pending SHALL live in prog_sequencer.

Verification
REQ-026 Program 0:3'b001, 1:3'b010, 2:halt; run; core model returns i_con_pcincr 3 cycles after each o_start.
-> Two o_start pulses with opcodes 1 then 2; o_halted=1; o_pc=2.
REQ-027 All 16 entries are non-halt; core model answers immediately.
-> o_pc wraps 15->0; o_start pulses spaced 2 cycles apart.
REQ-028 No i_con_pcincr after issue at pc=0.
-> o_fault=1 exactly TIMEOUT cycles after o_start; i_run then restarts with o_start at pc=0.
REQ-029 i_con_pcincr arrives on the timeout cycle.
-> No fault; pc increments.
REQ-030 i_stop asserted during WAIT at pc=1.
-> After i_con_pcincr: IDLE, o_pc=2, no further o_start; a write during WAIT is ignored and a write in IDLE is applied.
REQ-031 i_rst=0 mid-WAIT.
-> All outputs are 0 asynchronously; memory reads back 0.

Source files
------------

// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial core sequencer: word widths, default sizing and FSM states.
package bit_serial_pkg;
   localparam int unsigned OPC_W       = 3;
   localparam int unsigned WORD_W      = 4;
   localparam int unsigned DEPTH_DEF   = 16;
   localparam int unsigned TIMEOUT_DEF = 64;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StHalt,
      StFault
   } seq_state_e;
endpackage

// File: rtl/prog_mem.sv
// Program storage: DEPTH x WORD_W flop array, combinational read, clocked write, async clear.
module prog_mem
   import bit_serial_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wr_en_i,
   input  logic [AW-1:0]     wr_addr_i,
   input  logic [WORD_W-1:0] wr_data_i,
   input  logic [AW-1:0]     rd_addr_i,
   output logic [WORD_W-1:0] rd_data_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: steps through program memory, issuing one opcode at a time to a bit-serial
// core and waiting for its completion pulse, with halt markers, sticky stop and a timeout fault.
module prog_sequencer
   import bit_serial_pkg::*;
#(
   parameter int unsigned DEPTH   = DEPTH_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF,
   localparam int unsigned AW     = $clog2(DEPTH),
   localparam int unsigned CW     = $clog2(TIMEOUT + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_run,
   input  logic              i_stop,
   input  logic              i_wr_en,
   input  logic [AW-1:0]     i_wr_addr,
   input  logic [WORD_W-1:0] i_wr_data,
   input  logic              i_con_pcincr,
   output logic [OPC_W-1:0]  o_data_instruction,
   output logic              o_start,
   output logic [AW-1:0]     o_pc,
   output logic              o_busy,
   output logic              o_halted,
   output logic              o_fault
);

   logic [1:0]        rst_sync_q;
   logic              rst_n;
   seq_state_e        state_q, state_d;
   logic [AW-1:0]     pc_q, pc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              stop_q, stop_d;
   logic              wr_ok;
   logic              timeout_hit;
   logic [WORD_W-1:0] mem_word;

   // Assert immediately, release two edges after i_rst rises.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n = rst_sync_q[1];

   prog_mem #(
      .DEPTH(DEPTH)
   ) u_prog_mem (
      .clk_i     (i_clk),
      .rst_ni    (rst_n),
      .wr_en_i   (i_wr_en & wr_ok),
      .wr_addr_i (i_wr_addr),
      .wr_data_i (i_wr_data),
      .rd_addr_i (pc_q),
      .rd_data_o (mem_word)
   );

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pc_q    <= '0;
         cnt_q   <= '0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         stop_q  <= stop_d;
      end
   end

   // The counter value after this cycle would be TIMEOUT-1: last legal cycle for a completion.
   assign timeout_hit = (cnt_q == CW'(TIMEOUT - 2));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = '0;
      stop_d  = stop_q;
      o_start = 1'b0;
      wr_ok   = 1'b0;
      unique case (state_q)
         StIdle, StHalt, StFault: begin
            wr_ok = 1'b1;
            if (i_run) begin
               pc_d    = '0;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (i_stop) stop_d = 1'b1;
            if (mem_word[WORD_W-1]) begin
               state_d = StHalt;
               stop_d  = 1'b0;
            end else begin
               o_start = 1'b1;
               state_d = StWait;
            end
         end
         StWait: begin
            if (i_stop) stop_d = 1'b1;
            if (i_con_pcincr) begin
               pc_d = (pc_q == AW'(DEPTH - 1)) ? '0 : pc_q + 1'b1;
               if (stop_q || i_stop) begin
                  state_d = StIdle;
                  stop_d  = 1'b0;
               end else begin
                  state_d = StIssue;
               end
            end else if (timeout_hit) begin
               state_d = StFault;
               stop_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign o_busy             = (state_q == StIssue) || (state_q == StWait);
   assign o_halted           = (state_q == StHalt);
   assign o_fault            = (state_q == StFault);
   assign o_pc               = pc_q;
   assign o_data_instruction = o_busy ? mem_word[OPC_W-1:0] : '0;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: stimulus queues expected issues, a monitor checks each o_start.
module tb_prog_sequencer;
   import bit_serial_pkg::*;

   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 64;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_run = 1'b0;
   logic       i_stop = 1'b0;
   logic       i_wr_en = 1'b0;
   logic [3:0] i_wr_addr = 4'd0;
   logic [3:0] i_wr_data = 4'd0;
   logic       i_con_pcincr;
   logic [2:0] o_data_instruction;
   logic       o_start;
   logic [3:0] o_pc;
   logic       o_busy;
   logic       o_halted;
   logic       o_fault;

   prog_sequencer #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .i_clk              (i_clk),
      .i_rst              (i_rst),
      .i_run              (i_run),
      .i_stop             (i_stop),
      .i_wr_en            (i_wr_en),
      .i_wr_addr          (i_wr_addr),
      .i_wr_data          (i_wr_data),
      .i_con_pcincr       (i_con_pcincr),
      .o_data_instruction (o_data_instruction),
      .o_start            (o_start),
      .o_pc               (o_pc),
      .o_busy             (o_busy),
      .o_halted           (o_halted),
      .o_fault            (o_fault)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [3:0] pc;
      logic [2:0] op;
   } issue_t;

   issue_t exp_q[$];
   issue_t exp_e;
   int     total = 0;
   int     bad = 0;
   int     cyc = 0;
   int     starts = 0;
   int     last_start_cyc = -1;
   int     exp_gap = 0;
   int     core_delay = 0;
   int     pend = 0;
   logic   prev_start = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic issue_t mk(input int pc, input int op);
      issue_t r;
      r.pc = 4'(pc);
      r.op = 3'(op);
      return r;
   endfunction

   always @(posedge i_clk) cyc <= cyc + 1;

   // Monitor: every issue pulse must match the head of the expected queue.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         prev_start = 1'b0;
      end else begin
         if (o_start) begin
            starts++;
            chk("start_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               exp_e = exp_q.pop_front();
               chk("start_pc", int'(o_pc), int'(exp_e.pc));
               chk("start_op", int'(o_data_instruction), int'(exp_e.op));
            end
            if (exp_gap != 0 && last_start_cyc >= 0) begin
               chk("start_gap", cyc - last_start_cyc, exp_gap);
            end
            chk("start_not_consecutive", int'(prev_start), 0);
            last_start_cyc = cyc;
         end
         prev_start = o_start;
      end
   end

   // Core model: completion pulse core_delay cycles after each issue; 0 means never answer.
   always @(negedge i_clk) begin
      i_con_pcincr = 1'b0;
      if (!i_rst) begin
         pend = 0;
      end else begin
         if (pend > 0) begin
            pend--;
            if (pend == 0) i_con_pcincr = 1'b1;
         end
         if (o_start && core_delay > 0) pend = core_delay;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge i_clk);
         #1;
      end
   endtask

   task automatic wr(input int a, input int d);
      i_wr_en   = 1'b1;
      i_wr_addr = 4'(a);
      i_wr_data = 4'(d);
      tick(1);
      i_wr_en = 1'b0;
   endtask

   task automatic run_pulse();
      i_run = 1'b1;
      tick(1);
      i_run = 1'b0;
   endtask

   task automatic wr_run(input int a, input int d);
      i_run     = 1'b1;
      i_wr_en   = 1'b1;
      i_wr_addr = 4'(a);
      i_wr_data = 4'(d);
      tick(1);
      i_run   = 1'b0;
      i_wr_en = 1'b0;
   endtask

   task automatic wait_halt(input string name, input int max);
      int n = 0;
      while (!o_halted && n < max) begin
         tick(1);
         n++;
      end
      chk(name, int'(o_halted), 1);
   endtask

   task automatic wait_fault(input string name, input int max);
      int n = 0;
      while (!o_fault && n < max) begin
         tick(1);
         n++;
      end
      chk(name, int'(o_fault), 1);
   endtask

   task automatic wait_idle(input string name, input int max);
      int n = 0;
      while (o_busy && n < max) begin
         tick(1);
         n++;
      end
      chk(name, int'(o_busy), 0);
   endtask

   task automatic wait_starts(input string name, input int target, input int max);
      int n = 0;
      while (starts < target && n < max) begin
         tick(1);
         n++;
      end
      chk(name, starts, target);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_start"}, int'(o_start), 0);
      chk({tag, "_busy"}, int'(o_busy), 0);
      chk({tag, "_halted"}, int'(o_halted), 0);
      chk({tag, "_fault"}, int'(o_fault), 0);
      chk({tag, "_op"}, int'(o_data_instruction), 0);
      chk({tag, "_pc"}, int'(o_pc), 0);
   endtask

   initial begin
      int base;
      int s;

      #1 i_rst = 1'b0;
      #1 chk_all_zero("reset");
      tick(2);
      i_rst = 1'b1;
      tick(3);

      // Two instructions then a halt marker, core answers after 3 cycles.
      wr(0, 4'h1);
      wr(1, 4'h2);
      wr(2, 4'h8);
      core_delay = 3;
      base = starts;
      exp_q.push_back(mk(0, 1));
      exp_q.push_back(mk(1, 2));
      run_pulse();
      wait_halt("t1_halt", 40);
      chk("t1_starts", starts - base, 2);
      chk("t1_pc", int'(o_pc), 2);
      chk("t1_busy", int'(o_busy), 0);
      chk("t1_op_idle", int'(o_data_instruction), 0);

      // Full memory of non-halt words, immediate answers: wrap 15->0, issues 2 cycles apart.
      for (int i = 0; i < DEPTH; i++) wr(i, i & 7);
      core_delay     = 1;
      exp_gap        = 2;
      last_start_cyc = -1;
      base           = starts;
      for (int k = 0; k < 18; k++) exp_q.push_back(mk(k % DEPTH, (k % DEPTH) & 7));
      run_pulse();
      wait_starts("t2_starts", base + 18, 60);
      i_stop = 1'b1;
      tick(1);
      i_stop = 1'b0;
      wait_idle("t2_idle", 10);
      chk("t2_pc", int'(o_pc), 2);
      tick(5);
      chk("t2_no_more_starts", starts, base + 18);
      chk("t2_halted", int'(o_halted), 0);
      exp_gap = 0;

      // Completion one cycle too late: fault TIMEOUT cycles after issue, late pulse ignored.
      core_delay = TIMEOUT;
      exp_q.push_back(mk(0, 0));
      run_pulse();
      s = last_start_cyc;
      wait_fault("t3_fault", 100);
      chk("t3_fault_latency", cyc - s, TIMEOUT);
      chk("t3_pc", int'(o_pc), 0);
      chk("t3_busy", int'(o_busy), 0);
      tick(4);
      chk("t3_fault_hold", int'(o_fault), 1);
      chk("t3_pc_hold", int'(o_pc), 0);
      wr(1, 4'h8);
      core_delay = 1;
      exp_q.push_back(mk(0, 0));
      run_pulse();
      wait_halt("t3_rerun_halt", 20);
      chk("t3_fault_cleared", int'(o_fault), 0);
      chk("t3_rerun_pc", int'(o_pc), 1);

      // Completion exactly on the timeout cycle wins.
      wr(0, 4'h5);
      wr(1, 4'h3);
      wr(2, 4'h8);
      core_delay = TIMEOUT - 1;
      base = starts;
      exp_q.push_back(mk(0, 5));
      exp_q.push_back(mk(1, 3));
      run_pulse();
      wait_halt("t4_halt", 300);
      chk("t4_no_fault", int'(o_fault), 0);
      chk("t4_pc", int'(o_pc), 2);
      chk("t4_starts", starts - base, 2);

      // Stop during WAIT at pc=1; a write of a halt marker to entry 2 in WAIT must be dropped.
      wr(0, 4'h1);
      wr(1, 4'h2);
      wr(2, 4'h3);
      wr(3, 4'h8);
      core_delay = 3;
      base = starts;
      exp_q.push_back(mk(0, 1));
      exp_q.push_back(mk(1, 2));
      run_pulse();
      wait_starts("t5_second_start", base + 2, 20);
      tick(1);
      i_stop    = 1'b1;
      i_wr_en   = 1'b1;
      i_wr_addr = 4'd2;
      i_wr_data = 4'h8;
      tick(1);
      i_stop  = 1'b0;
      i_wr_en = 1'b0;
      wait_idle("t5_idle", 10);
      chk("t5_pc", int'(o_pc), 2);
      chk("t5_halted", int'(o_halted), 0);
      chk("t5_fault", int'(o_fault), 0);
      tick(6);
      chk("t5_no_more_starts", starts, base + 2);
      core_delay = 1;
      base = starts;
      exp_q.push_back(mk(0, 7));
      exp_q.push_back(mk(1, 2));
      exp_q.push_back(mk(2, 3));
      wr_run(0, 4'h7);
      wait_halt("t5_halt", 30);
      chk("t5_halt_pc", int'(o_pc), 3);
      chk("t5_halt_starts", starts - base, 3);

      // Reset mid-WAIT: outputs drop without a clock, memory comes back cleared.
      core_delay = 0;
      exp_q.push_back(mk(0, 7));
      run_pulse();
      tick(5);
      chk("t6_busy_before", int'(o_busy), 1);
      #2 i_rst = 1'b0;
      #1 chk_all_zero("t6_async");
      tick(3);
      chk("t6_in_reset_start", int'(o_start), 0);
      chk("t6_in_reset_busy", int'(o_busy), 0);
      i_rst = 1'b1;
      tick(3);
      chk("t6_after_release_busy", int'(o_busy), 0);
      core_delay = 1;
      base = starts;
      for (int k = 0; k < 5; k++) exp_q.push_back(mk(k, 0));
      run_pulse();
      wait_starts("t6_starts", base + 5, 30);
      i_stop = 1'b1;
      tick(1);
      i_stop = 1'b0;
      wait_idle("t6_idle", 10);
      chk("t6_pc", int'(o_pc), 5);
      chk("t6_halted", int'(o_halted), 0);

      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion before it");
      $fatal(1, "watchdog");
   end

endmodule
